channel_frame_sender: RTL and testbench

Consumer side of the channel control register set. It takes the latched channel configuration (frame length, blank length, start/stop, total/cut counts, FIFO clear, header enable) and drains the channel data FIFO into a framed stream. Each frame can carry an optional header word, and frames are separated by a programmable blank gap. It sits between the channel FIFO (first-word-fall-through) and the downstream link serializer.

---
 rtl/chan_tx_pkg.sv | 24 ++
 rtl/edge_rise.sv | 24 ++
 rtl/channel_frame_sender.sv | 151 +++++++++++++++
 tb/tb_channel_frame_sender.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_tx_pkg.sv
// Shared definitions for the channel frame sender: FSM encodings, defaults
// and the configuration snapshot captured at run start.
package chan_tx_pkg;

  localparam int          DW_DEF        = 16;
  localparam logic [15:0] HEAD_WORD_DEF = 16'hEB90;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_CUT   = 3'd1;
  localparam state_t S_HEAD  = 3'd2;
  localparam state_t S_DATA  = 3'd3;
  localparam state_t S_BLANK = 3'd4;
  localparam state_t S_DONE  = 3'd5;

  typedef struct packed {
    logic [15:0] frame_len;   // already forced to >= 1
    logic [15:0] blank_len;
    logic [31:0] total;
    logic [31:0] cut;
    logic        head_en;
  } cfg_t;

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector. The first cycle after reset only learns the
// input level, so a level already high at reset release never fires.
module edge_rise (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic pulse
);

  logic prev, armed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev  <= 1'b0;
      armed <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= din;
      armed <= 1'b1;
      pulse <= armed & din & ~prev;
    end
  end

endmodule

// File: rtl/channel_frame_sender.sv
// Drains a FWFT channel FIFO into a framed stream: optional header per frame,
// programmable blank gap between frames, leading-word cut, stop and abort.
module channel_frame_sender
  import chan_tx_pkg::*;
#(
  parameter int          DW        = DW_DEF,
  parameter logic [DW-1:0] HEAD_WORD = DW'(HEAD_WORD_DEF)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [15:0]   frame_len,
  input  logic [15:0]   blank_len,
  input  logic          start_send,
  input  logic          stop_send,
  input  logic [31:0]   datnum_total,
  input  logic [31:0]   datnum_cut,
  input  logic          fifo_clr_req,
  input  logic          head_en,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_rd_en,
  output logic          fifo_clr,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          tx_sof,
  output logic          tx_eof,
  output logic          busy,
  output logic          done,
  output logic [31:0]   sent_cnt
);

  logic start_edge, stop_edge, clr_edge;

  edge_rise u_start (.clk(clk), .reset_n(reset_n), .din(start_send),   .pulse(start_edge));
  edge_rise u_stop  (.clk(clk), .reset_n(reset_n), .din(stop_send),    .pulse(stop_edge));
  edge_rise u_clr   (.clk(clk), .reset_n(reset_n), .din(fifo_clr_req), .pulse(clr_edge));

  state_t      state;
  cfg_t        cfg;
  logic [15:0] word_cnt, blank_cnt;
  logic [31:0] cut_cnt;
  logic        stop_pend;

  logic   hs, last_word;
  state_t frame_start;

  assign hs          = tx_valid & tx_ready;
  assign last_word   = (word_cnt == cfg.frame_len - 16'd1) || (sent_cnt == cfg.total - 32'd1);
  assign frame_start = cfg.head_en ? S_HEAD : S_DATA;
  assign fifo_clr    = clr_edge;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

  // The abort cycle withholds valid and pops so nothing is consumed while the FIFO clears.
  always_comb begin
    tx_valid   = 1'b0;
    tx_data    = '0;
    tx_sof     = 1'b0;
    tx_eof     = 1'b0;
    fifo_rd_en = 1'b0;
    if (!clr_edge) begin
      case (state)
        S_CUT:  fifo_rd_en = !fifo_empty;
        S_HEAD: begin
          tx_valid = 1'b1;
          tx_data  = HEAD_WORD;
          tx_sof   = 1'b1;
        end
        S_DATA: if (!fifo_empty) begin
          tx_valid   = 1'b1;
          tx_data    = fifo_dout;
          tx_sof     = !cfg.head_en && (word_cnt == 16'd0);
          tx_eof     = last_word;
          fifo_rd_en = tx_ready;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cfg       <= '0;
      sent_cnt  <= '0;
      word_cnt  <= '0;
      blank_cnt <= '0;
      cut_cnt   <= '0;
      stop_pend <= 1'b0;
    end else if (clr_edge) begin
      state     <= S_IDLE;
      stop_pend <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start_edge && !stop_edge) begin
          sent_cnt      <= '0;
          word_cnt      <= '0;
          cut_cnt       <= '0;
          stop_pend     <= 1'b0;
          cfg.frame_len <= (frame_len == 16'd0) ? 16'd1 : frame_len;
          cfg.blank_len <= blank_len;
          cfg.total     <= datnum_total;
          cfg.cut       <= datnum_cut;
          cfg.head_en   <= head_en;
          if (datnum_total == 32'd0) state <= S_DONE;
          else if (datnum_cut != 32'd0) state <= S_CUT;
          else if (head_en) state <= S_HEAD;
          else state <= S_DATA;
        end
        S_CUT: begin
          if (stop_edge) state <= S_DONE;
          else if (fifo_rd_en) begin
            cut_cnt <= cut_cnt + 32'd1;
            if (cut_cnt == cfg.cut - 32'd1) state <= frame_start;
          end
        end
        S_HEAD: begin
          if (stop_edge) stop_pend <= 1'b1;
          if (hs) state <= S_DATA;
        end
        S_DATA: begin
          if (stop_edge) stop_pend <= 1'b1;
          if (hs) begin
            sent_cnt <= sent_cnt + 32'd1;
            word_cnt <= word_cnt + 16'd1;
            if (last_word) begin
              word_cnt <= '0;
              // a stop arriving on the eof beat still ends the run here
              if (sent_cnt == cfg.total - 32'd1 || stop_pend || stop_edge) state <= S_DONE;
              else if (cfg.blank_len != 16'd0) begin
                blank_cnt <= '0;
                state     <= S_BLANK;
              end else state <= frame_start;
            end
          end
        end
        S_BLANK: begin
          if (stop_edge) state <= S_DONE;
          else begin
            blank_cnt <= blank_cnt + 16'd1;
            if (blank_cnt == cfg.blank_len - 16'd1) state <= frame_start;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_frame_sender.sv
// Directed bench for channel_frame_sender: FIFO model, expected-word queue and
// an independent monitor that pops and compares on each stream handshake.
module tb_channel_frame_sender;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] frame_len, blank_len;
  logic        start_send, stop_send, fifo_clr_req, head_en;
  logic [31:0] datnum_total, datnum_cut;
  logic        fifo_empty;
  logic [15:0] fifo_dout;
  logic        fifo_rd_en, fifo_clr;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready, tx_sof, tx_eof;
  logic        busy, done;
  logic [31:0] sent_cnt;

  always #5 clk = ~clk;

  channel_frame_sender dut (
    .clk(clk), .reset_n(reset_n), .frame_len(frame_len), .blank_len(blank_len),
    .start_send(start_send), .stop_send(stop_send), .datnum_total(datnum_total),
    .datnum_cut(datnum_cut), .fifo_clr_req(fifo_clr_req), .head_en(head_en),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .fifo_clr(fifo_clr), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sof(tx_sof), .tx_eof(tx_eof), .busy(busy), .done(done), .sent_cnt(sent_cnt)
  );

  // FWFT FIFO model
  logic [15:0] mem [64];
  logic [5:0]  wr_ptr, rd_ptr;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_dout  = mem[rd_ptr];
  always @(posedge clk or negedge reset_n)
    if (!reset_n) rd_ptr <= '0;
    else if (fifo_clr) rd_ptr <= wr_ptr;
    else if (fifo_rd_en && !fifo_empty) rd_ptr <= rd_ptr + 6'd1;

  typedef struct packed { logic [15:0] d; logic s; logic e; } tw_t;
  tw_t sb [$];

  int checks = 0, errors = 0;
  int done_cnt = 0, last_gap = -1, gap = 0;
  bit in_gap = 0, prev_stall = 0, tog_on = 0;
  tw_t prev_w;

  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      if (done) done_cnt++;
      if (prev_stall && !fifo_clr) begin
        checks++;
        if (!(tx_valid && tx_data == prev_w.d && tx_sof == prev_w.s && tx_eof == prev_w.e)) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%h s=%0b e=%0b, required held d=%h s=%0b e=%0b",
                   tx_valid, tx_data, tx_sof, tx_eof, prev_w.d, prev_w.s, prev_w.e);
        end
      end
      if (in_gap && tx_valid) begin last_gap = gap; in_gap = 0; end
      else if (in_gap) gap++;
      if (tx_valid && tx_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got d=%h s=%0b e=%0b, required none", tx_data, tx_sof, tx_eof);
        end else begin
          tw_t x;
          x = sb.pop_front();
          if (tx_data !== x.d || tx_sof !== x.s || tx_eof !== x.e) begin
            errors++;
            $display("FAIL stream_word: got d=%h s=%0b e=%0b, required d=%h s=%0b e=%0b",
                     tx_data, tx_sof, tx_eof, x.d, x.s, x.e);
          end
        end
        if (tx_eof) begin in_gap = 1; gap = 0; end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_w     = '{tx_data, tx_sof, tx_eof};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic ex(input logic [15:0] d, input logic s, input logic e);
    sb.push_back('{d, s, e});
  endtask

  task automatic set_cfg(input logic [15:0] fl, input logic [15:0] bl,
                         input logic [31:0] tot, input logic [31:0] ct, input logic he);
    frame_len = fl; blank_len = bl; datnum_total = tot; datnum_cut = ct; head_en = he;
  endtask

  task automatic pulse_start();
    @(negedge clk); start_send = 1'b1;
    repeat (2) @(negedge clk);
    start_send = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clk);
    #2;
    chk({name, "_done_seen"}, done_cnt - d0, 1);
  endtask

  initial begin
    wr_ptr = '0;
    reset_n = 1'b0; start_send = 1'b1; stop_send = 1'b0; fifo_clr_req = 1'b0;
    tx_ready = 1'b1;
    set_cfg(16'd4, 16'd2, 32'd8, 32'd0, 1'b1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    // start held high through reset: must not launch a run
    repeat (5) @(negedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_sent_cnt", sent_cnt, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    start_send = 1'b0;
    @(negedge clk);

    // scenario 1: two headed frames with a 2-cycle blank
    for (int i = 1; i <= 8; i++) push(16'(i));
    ex(16'hEB90, 1, 0); ex(1, 0, 0); ex(2, 0, 0); ex(3, 0, 0); ex(4, 0, 1);
    ex(16'hEB90, 1, 0); ex(5, 0, 0); ex(6, 0, 0); ex(7, 0, 0); ex(8, 0, 1);
    pulse_start();
    wait_done("s1");
    chk("s1_sent_cnt", sent_cnt, 8);
    chk("s1_blank_gap", 32'(last_gap), 2);
    chk("s1_drained", sb.size(), 0);

    // scenario 3: same run under toggling tx_ready
    for (int i = 1; i <= 8; i++) push(16'(i));
    ex(16'hEB90, 1, 0); ex(1, 0, 0); ex(2, 0, 0); ex(3, 0, 0); ex(4, 0, 1);
    ex(16'hEB90, 1, 0); ex(5, 0, 0); ex(6, 0, 0); ex(7, 0, 0); ex(8, 0, 1);
    tog_on = 1;
    fork
      while (tog_on) begin @(negedge clk); tx_ready = ~tx_ready; end
    join_none
    pulse_start();
    wait_done("s3");
    tog_on = 0;
    repeat (3) @(negedge clk);
    tx_ready = 1'b1;
    chk("s3_sent_cnt", sent_cnt, 8);
    chk("s3_drained", sb.size(), 0);

    // scenario 2: cut three leading words
    set_cfg(16'd5, 16'd0, 32'd2, 32'd3, 1'b0);
    for (int i = 10; i <= 14; i++) push(16'(i));
    ex(13, 1, 0); ex(14, 0, 1);
    pulse_start();
    wait_done("s2");
    chk("s2_sent_cnt", sent_cnt, 2);
    chk("s2_fifo_empty", fifo_empty, 1);
    chk("s2_drained", sb.size(), 0);

    // scenario 4: stop after 2nd data word ends run at frame eof
    set_cfg(16'd4, 16'd2, 32'd12, 32'd0, 1'b0);
    for (int i = 1; i <= 12; i++) push(16'(i));
    ex(1, 1, 0); ex(2, 0, 0); ex(3, 0, 0); ex(4, 0, 1);
    pulse_start();
    begin
      int n = 0;
      while (sent_cnt != 32'd2 && n < 200) begin @(negedge clk); n++; end
      chk("s4_reach_2", sent_cnt, 2);
    end
    stop_send = 1'b1;
    wait_done("s4");
    stop_send = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    chk("s4_sent_cnt", sent_cnt, 4);
    chk("s4_idle", busy, 0);
    chk("s4_drained", sb.size(), 0);

    // scenario 5: abort mid-DATA with the sink stalled (FIFO still holds 5..12)
    set_cfg(16'd4, 16'd0, 32'd8, 32'd0, 1'b0);
    tx_ready = 1'b0;
    pulse_start();
    begin
      int n = 0, d0;
      d0 = done_cnt;
      while (!tx_valid && n < 50) begin @(negedge clk); #2; n++; end
      chk("s5_valid_before", tx_valid, 1);
      fifo_clr_req = 1'b1;
      n = 0;
      while (!fifo_clr && n < 20) begin @(negedge clk); #2; n++; end
      chk("s5_clr_pulse", fifo_clr, 1);
      @(negedge clk); #2;
      chk("s5_clr_one_cycle", fifo_clr, 0);
      chk("s5_valid_after", tx_valid, 0);
      chk("s5_busy_after", busy, 0);
      chk("s5_fifo_empty", fifo_empty, 1);
      repeat (3) @(negedge clk); #2;
      chk("s5_no_done", done_cnt - d0, 0);
    end
    fifo_clr_req = 1'b0;
    tx_ready = 1'b1;

    // simultaneous start and stop in IDLE: stop wins
    @(negedge clk); start_send = 1'b1; stop_send = 1'b1;
    repeat (4) @(negedge clk); #2;
    chk("ss_busy", busy, 0);
    start_send = 1'b0; stop_send = 1'b0;

    // scenario 6a: total=0 gives immediate done, no stream
    set_cfg(16'd4, 16'd0, 32'd0, 32'd0, 1'b1);
    pulse_start();
    wait_done("s6a");
    chk("s6a_sent_cnt", sent_cnt, 0);

    // scenario 6b: frame_len=0 acts as frame of one
    set_cfg(16'd0, 16'd0, 32'd3, 32'd0, 1'b0);
    push(16'd21); push(16'd22); push(16'd23);
    ex(21, 1, 1); ex(22, 1, 1); ex(23, 1, 1);
    pulse_start();
    wait_done("s6b");
    chk("s6b_sent_cnt", sent_cnt, 3);
    chk("s6b_drained", sb.size(), 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
